// File: rtl/vga_timing_gen_if.sv
// Pixel descriptor stream (coordinates, syncs, data-enable) from the timing generator to the drawers.
interface pixels_if #(
   parameter int PIX_X_W = 12,
   parameter int PIX_Y_W = 12
);
   logic [PIX_X_W-1:0] x;
   logic [PIX_Y_W-1:0] y;
   logic               hs;
   logic               vs;
   logic               de;

   modport out (output x, y, hs, vs, de);
   modport in  (input  x, y, hs, vs, de);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks h/v counters over the frame and registers the pixel descriptor.
// One cycle from counter state to outputs; pix_en_i low freezes counters and every output.
module vga_timing_gen #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0,
   parameter int   PIX_X_W     = 12,
   parameter int   PIX_Y_W     = 12,
   parameter int   FRAME_CNT_W = 8
) (
   input  logic                   clk_25_i,
   input  logic                   rst_i,
   input  logic                   pix_en_i,
   pixels_if.out                  pix_if,
   output logic                   sof_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (2 ** PIX_X_W)) begin : g_h_too_wide
      $error("vga_timing_gen: H_TOTAL-1 does not fit in PIX_X_W bits");
   end
   if (V_TOTAL > (2 ** PIX_Y_W)) begin : g_v_too_wide
      $error("vga_timing_gen: V_TOTAL-1 does not fit in PIX_Y_W bits");
   end

   // Inclusive bounds so that no constant ever needs the full 2^W value.
   localparam logic [PIX_X_W-1:0] H_LAST     = PIX_X_W'(H_TOTAL - 1);
   localparam logic [PIX_X_W-1:0] H_ACT_LAST = PIX_X_W'(H_ACTIVE - 1);
   localparam logic [PIX_X_W-1:0] HS_FIRST   = PIX_X_W'(H_ACTIVE + H_FP);
   localparam logic [PIX_X_W-1:0] HS_LAST    = PIX_X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [PIX_Y_W-1:0] V_LAST     = PIX_Y_W'(V_TOTAL - 1);
   localparam logic [PIX_Y_W-1:0] V_ACT_LAST = PIX_Y_W'(V_ACTIVE - 1);
   localparam logic [PIX_Y_W-1:0] VS_FIRST   = PIX_Y_W'(V_ACTIVE + V_FP);
   localparam logic [PIX_Y_W-1:0] VS_LAST    = PIX_Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [PIX_X_W-1:0]     h_cnt_q, h_cnt_d;
   logic [PIX_Y_W-1:0]     v_cnt_q, v_cnt_d;
   logic [PIX_X_W-1:0]     x_q, x_d;
   logic [PIX_Y_W-1:0]     y_q, y_d;
   logic                   hs_q, hs_d;
   logic                   vs_q, vs_d;
   logic                   de_q, de_d;
   logic                   sof_q, sof_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   h_wrap, v_wrap;

   always_comb begin
      h_wrap  = (h_cnt_q == H_LAST);
      v_wrap  = (v_cnt_q == V_LAST);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + PIX_X_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + PIX_Y_W'(1);
      end

      x_d   = h_cnt_q;
      y_d   = v_cnt_q;
      de_d  = (h_cnt_q <= H_ACT_LAST) && (v_cnt_q <= V_ACT_LAST);
      hs_d  = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? HS_POL : ~HS_POL;
      vs_d  = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? VS_POL : ~VS_POL;
      sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      // The frame counts as complete on the edge that presents its last pixel.
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(h_wrap && v_wrap);
   end

   always_ff @(posedge clk_25_i) begin
      if (rst_i) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         de_q        <= 1'b0;
         sof_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else if (pix_en_i) begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         sof_q       <= sof_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_if.x    = x_q;
   assign pix_if.y    = y_q;
   assign pix_if.hs   = hs_q;
   assign pix_if.vs   = vs_q;
   assign pix_if.de   = de_q;
   assign sof_o       = sof_q;
   assign frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 16x10 raster; a second instance covers active-high syncs and a 2-bit frame counter.
module tb_vga_timing_gen;
   localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 3;
   localparam int V_A = 4, V_F = 2, V_S = 2, V_B = 2;
   localparam int HT  = H_A + H_F + H_S + H_B;
   localparam int VT  = V_A + V_F + V_S + V_B;
   localparam int FR  = HT * VT;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        hs;
      logic        vs;
      logic        de;
      logic        sof;
      logic [7:0]  fc;
      logic        hs_p;
      logic        vs_p;
      logic [1:0]  fc_p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_en = 1'b0;
   logic       sof_a, sof_b;
   logic [7:0] fc_a;
   logic [1:0] fc_b;

   int   checks = 0;
   int   errors = 0;
   int   mh = 0, mv = 0, mf = 0;
   exp_t held;
   exp_t exp_q[$];

   pixels_if #(.PIX_X_W(12), .PIX_Y_W(12)) pa ();
   pixels_if #(.PIX_X_W(12), .PIX_Y_W(12)) pb ();

   vga_timing_gen #(
      .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
      .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIX_X_W(12), .PIX_Y_W(12), .FRAME_CNT_W(8)
   ) dut (
      .clk_25_i(clk), .rst_i(rst), .pix_en_i(pix_en),
      .pix_if(pa), .sof_o(sof_a), .frame_cnt_o(fc_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
      .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_X_W(12), .PIX_Y_W(12), .FRAME_CNT_W(2)
   ) dut_pol (
      .clk_25_i(clk), .rst_i(rst), .pix_en_i(pix_en),
      .pix_if(pb), .sof_o(sof_b), .frame_cnt_o(fc_b)
   );

   always #5 clk = ~clk;

   function automatic exp_t reset_exp();
      exp_t e;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
   endfunction

   function automatic exp_t desc(input int h, input int v, input int f);
      exp_t e;
      e.x    = 12'(h);
      e.y    = 12'(v);
      e.de   = (h < H_A) && (v < V_A);
      e.hs   = !((h >= H_A + H_F) && (h < H_A + H_F + H_S));
      e.vs   = !((v >= V_A + V_F) && (v < V_A + V_F + V_S));
      e.sof  = (h == 0) && (v == 0);
      e.fc   = 8'(f);
      e.hs_p = ~e.hs;
      e.vs_p = ~e.vs;
      e.fc_p = 2'(f);
      return e;
   endfunction

   // Drives one cycle, queues what both DUTs must show after the edge, then pops and compares.
   task automatic cycle(input logic r, input logic en);
      exp_t e, o;
      @(negedge clk);
      rst    = r;
      pix_en = en;
      if (r) begin
         e  = reset_exp();
         mh = 0; mv = 0; mf = 0;
      end else if (en) begin
         if (mh == HT - 1 && mv == VT - 1) mf = mf + 1;
         e = desc(mh, mv, mf);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end else begin
         e = held;
      end
      held = e;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = '0;
      o.x = pa.x; o.y = pa.y; o.hs = pa.hs; o.vs = pa.vs; o.de = pa.de;
      o.sof = sof_a; o.fc = fc_a; o.hs_p = pb.hs; o.vs_p = pb.vs; o.fc_p = fc_b;
      checks++;
      if ({o.x, o.y, o.hs, o.vs, o.de, o.sof, o.fc} !== {e.x, e.y, e.hs, e.vs, e.de, e.sof, e.fc}) begin
         errors++;
         $display("FAIL pixel t=%0t got x=%0d y=%0d hs=%b vs=%b de=%b sof=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b de=%b sof=%b fc=%0d",
                  $time, o.x, o.y, o.hs, o.vs, o.de, o.sof, o.fc, e.x, e.y, e.hs, e.vs, e.de, e.sof, e.fc);
      end
      checks++;
      if ({pb.x, pb.y, pb.de, sof_b, o.hs_p, o.vs_p, o.fc_p} !== {e.x, e.y, e.de, e.sof, e.hs_p, e.vs_p, e.fc_p}) begin
         errors++;
         $display("FAIL pol_pixel t=%0t got x=%0d y=%0d hs=%b vs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b fc=%0d",
                  $time, pb.x, pb.y, o.hs_p, o.vs_p, o.fc_p, e.x, e.y, e.hs_p, e.vs_p, e.fc_p);
      end
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      checks++;
      if ({pa.x, pa.y, pa.de, pa.hs, pa.vs, sof_a, fc_a} !== {24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values got x=%0d y=%0d de=%b hs=%b vs=%b sof=%b fc=%0d", pa.x, pa.y, pa.de, pa.hs, pa.vs, sof_a, fc_a);
      end
      cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, pa.y, pa.de, sof_a, pa.hs, pa.vs} !== {24'd0, 4'b1111}) begin
         errors++;
         $display("FAIL first_pixel got x=%0d y=%0d de=%b sof=%b hs=%b vs=%b want 0 0 1 1 1 1", pa.x, pa.y, pa.de, sof_a, pa.hs, pa.vs);
      end
      cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, sof_a} !== {12'd1, 1'b0}) begin
         errors++;
         $display("FAIL second_pixel got x=%0d sof=%b want x=1 sof=0", pa.x, sof_a);
      end
   endtask

   task automatic test_full_frames();
      int n_de = 0, n_hs = 0, hs_low = 0, n_vs = 0, vs_low = 0, n_sof = 0;
      int bad_start = 0, bad_sof = 0, last_sof = -1;
      logic prev_hs = 1'b1, prev_vs = 1'b1;
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 2 * FR; i++) begin
         cycle(1'b0, 1'b1);
         if (pa.de) n_de++;
         if (!pa.hs) hs_low++;
         if (!pa.vs) vs_low++;
         if (prev_hs && !pa.hs) begin
            n_hs++;
            if (pa.x !== 12'(H_A + H_F)) bad_start++;
         end
         if (prev_vs && !pa.vs) begin
            n_vs++;
            if ({pa.x, pa.y} !== {12'd0, 12'(V_A + V_F)}) bad_start++;
         end
         if (sof_a) begin
            n_sof++;
            if (last_sof >= 0 && i - last_sof != FR) bad_sof++;
            last_sof = i;
         end
         prev_hs = pa.hs;
         prev_vs = pa.vs;
         if (i == FR - 1) begin
            checks++;
            if (fc_a !== 8'd1) begin errors++; $display("FAIL frame_cnt_1 got %0d want 1", fc_a); end
         end
      end
      checks++;
      if (n_de != 2 * H_A * V_A) begin errors++; $display("FAIL de_count got %0d want %0d", n_de, 2 * H_A * V_A); end
      checks++;
      if (n_hs != 2 * VT || hs_low != 2 * VT * H_S) begin
         errors++; $display("FAIL hs_pulses got %0d/%0d want %0d/%0d", n_hs, hs_low, 2 * VT, 2 * VT * H_S);
      end
      checks++;
      if (n_vs != 2 || vs_low != 2 * V_S * HT) begin
         errors++; $display("FAIL vs_window got %0d/%0d want 2/%0d", n_vs, vs_low, 2 * V_S * HT);
      end
      checks++;
      if (bad_start != 0) begin errors++; $display("FAIL sync_start got %0d bad want 0", bad_start); end
      checks++;
      if (n_sof != 2 || bad_sof != 0) begin errors++; $display("FAIL sof_period got %0d sofs %0d bad want 2 0", n_sof, bad_sof); end
      checks++;
      if (fc_a !== 8'd2) begin errors++; $display("FAIL frame_cnt_2 got %0d want 2", fc_a); end
   endtask

   task automatic test_enable_toggle();
      int n_de = 0;
      cycle(1'b1, 1'b0);
      for (int i = 0; i < FR; i++) begin
         cycle(1'b0, 1'b1);
         if (pa.de) n_de++;
         cycle(1'b0, 1'b0);
      end
      checks++;
      if (n_de != H_A * V_A || fc_a !== 8'd1) begin
         errors++; $display("FAIL toggle_frame got de=%0d fc=%0d want %0d 1", n_de, fc_a, H_A * V_A);
      end
   endtask

   task automatic test_wrap();
      cycle(1'b1, 1'b0);
      repeat (FR) cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, pa.y, fc_a} !== {12'(HT - 1), 12'(VT - 1), 8'd1}) begin
         errors++; $display("FAIL last_pixel got x=%0d y=%0d fc=%0d want %0d %0d 1", pa.x, pa.y, fc_a, HT - 1, VT - 1);
      end
      cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, pa.y, sof_a} !== {24'd0, 1'b1}) begin
         errors++; $display("FAIL wrap_pixel got x=%0d y=%0d sof=%b want 0 0 1", pa.x, pa.y, sof_a);
      end
   endtask

   task automatic test_frame_wrap();
      cycle(1'b1, 1'b0);
      for (int f = 0; f < 256; f++) begin
         repeat (FR) cycle(1'b0, 1'b1);
         if (f == 254) begin
            checks++;
            if ({fc_a, fc_b} !== {8'd255, 2'd3}) begin errors++; $display("FAIL frame_cnt_255 got %0d/%0d want 255/3", fc_a, fc_b); end
         end
      end
      checks++;
      if ({fc_a, fc_b} !== 10'd0) begin errors++; $display("FAIL frame_cnt_wrap got %0d/%0d want 0/0", fc_a, fc_b); end
   endtask

   task automatic test_mid_reset();
      cycle(1'b1, 1'b0);
      repeat (FR + 3 * HT + 6 + 1) cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, pa.y, fc_a} !== {12'd6, 12'd3, 8'd1}) begin
         errors++; $display("FAIL mid_pos got x=%0d y=%0d fc=%0d want 6 3 1", pa.x, pa.y, fc_a);
      end
      cycle(1'b1, 1'b0);
      checks++;
      if ({pa.x, pa.y, pa.de, fc_a} !== {24'd0, 1'b0, 8'd0}) begin
         errors++; $display("FAIL mid_reset got x=%0d y=%0d de=%b fc=%0d want 0 0 0 0", pa.x, pa.y, pa.de, fc_a);
      end
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      checks++;
      if ({pa.x, pa.y, sof_a, fc_a} !== {24'd0, 1'b1, 8'd0}) begin
         errors++; $display("FAIL restart got x=%0d y=%0d sof=%b fc=%0d want 0 0 1 0", pa.x, pa.y, sof_a, fc_a);
      end
   endtask

   task automatic test_polarity();
      int n_hs = 0, n_vs = 0, bad = 0;
      cycle(1'b1, 1'b0);
      checks++;
      if ({pb.hs, pb.vs} !== 2'b00) begin errors++; $display("FAIL pol_idle got hs=%b vs=%b want 0 0", pb.hs, pb.vs); end
      repeat (FR) begin
         cycle(1'b0, 1'b1);
         if (pb.hs) begin
            n_hs++;
            if (pb.x < 12'(H_A + H_F) || pb.x > 12'(H_A + H_F + H_S - 1)) bad++;
         end
         if (pb.vs) begin
            n_vs++;
            if (pb.y < 12'(V_A + V_F) || pb.y > 12'(V_A + V_F + V_S - 1)) bad++;
         end
      end
      checks++;
      if (n_hs != VT * H_S || n_vs != V_S * HT || bad != 0) begin
         errors++; $display("FAIL pol_sync got hs=%0d vs=%0d bad=%0d want %0d %0d 0", n_hs, n_vs, bad, VT * H_S, V_S * HT);
      end
   endtask

   initial begin
      test_reset();
      test_full_frames();
      test_enable_toggle();
      test_wrap();
      test_mid_reset();
      test_polarity();
      test_frame_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
